dot_acc: RTL and testbench

Sequencing stage directly upstream of the `mul` shift-add multiplier. Accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and issues each pair to `mul` via its `start`/`busy` protocol. Accumulates the 16-bit products of every `LEN` consecutive pairs and presents the dot product on a valid/ready output. `mul` and its `sum` adder are instantiated beside this block by the parent; `dot_acc` only drives and observes `mul`'s ports.

---
 rtl/dot_acc_pkg.sv | 17 +
 rtl/dot_acc.sv | 101 ++++++++++
 tb/tb_dot_acc.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_acc_pkg.sv
// Shared widths and FSM state encoding for the dot-product sequencer that
// feeds the shift-add multiplier.
package dot_acc_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/dot_acc.sv
// Dot-product sequencer: takes operand pairs, issues each to the external
// multiplier, and accumulates LEN products into one result.
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_start,
    input  logic              mul_busy,
    input  logic [PROD_W-1:0] mul_result
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Operand latches only move on an accepted pair, so mul sees stable
    // operands for the whole multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a <= in_a;
                        mul_b <= in_b;
                    end
                end
                ACC: begin
                    acc <= acc + ACC_W'(mul_result);
                    cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                end
                OUT: begin
                    if (out_ready) begin
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // GUARD exists because mul raises busy one cycle after start.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = GUARD;
            end
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (!mul_busy) begin
                    state_nxt = ACC;
                end
            end
            ACC: state_nxt = (cnt == LAST) ? OUT : IDLE;
            OUT: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc with a behavioural multiplier beside it
// and a plain-arithmetic dot-product reference.
module tb_dot_acc;

    localparam int LEN   = 4;
    localparam int ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic             mul_start;
    logic             mul_busy = 1'b0;
    logic [15:0]      mul_result = '0;

    int checks = 0;
    int passed = 0;

    dot_acc #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_busy(mul_busy), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: busy rises after start, result is garbage until done.
    int         force_k = 0;
    int         left = 0;
    logic [7:0] ma = '0;
    logic [7:0] mb = '0;
    always @(posedge clk) begin
        if (rst) begin
            mul_busy   <= 1'b0;
            mul_result <= '0;
            left       <= 0;
        end else if (mul_start) begin
            mul_busy   <= 1'b1;
            left       <= (force_k > 0) ? force_k : int'($urandom_range(1, 5));
            mul_result <= 16'($urandom);
            ma         <= mul_a;
            mb         <= mul_b;
        end else if (mul_busy) begin
            if (left <= 1) begin
                mul_busy   <= 1'b0;
                mul_result <= 16'(ma * mb);
            end else begin
                left <= left - 1;
            end
        end
    end

    logic [ACC_W-1:0] results[$];
    int  start_pulses = 0;
    int  wide_starts  = 0;
    int  valid_pulses = 0;
    bit  prev_start   = 1'b0;
    bit  prev_valid   = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) results.push_back(out_data);
            if (mul_start && !prev_start) start_pulses++;
            if (mul_start && prev_start) wide_starts++;
            if (out_valid && !prev_valid) valid_pulses++;
        end
        prev_start = mul_start;
        prev_valid = out_valid;
    end

    function automatic logic [ACC_W-1:0] ref_dot(input int a[$], input int b[$]);
        longint s = 0;
        foreach (a[i]) s += longint'(a[i]) * longint'(b[i]);
        return ACC_W'(s % (longint'(1) << ACC_W));
    endfunction

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit keep);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mul_a !== a || mul_b !== b)
            $display("[TB] FAIL operand_latch: mul_a=%0d mul_b=%0d required %0d %0d", mul_a, mul_b, a, b);
        else passed++;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t = 0;
        while (results.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (results.size() < n) begin
            checks++;
            $display("[TB] FAIL result_timeout: got %0d results required %0d", results.size(), n);
            while (results.size() < n) results.push_back('x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b1)  $display("[TB] FAIL reset_in_ready: %b required 1", in_ready);   else passed++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: %b required 0", out_valid); else passed++;
        if (out_data !== '0)    $display("[TB] FAIL reset_out_data: %0d required 0", out_data);  else passed++;
        if (mul_start !== 1'b0) $display("[TB] FAIL reset_mul_start: %b required 0", mul_start); else passed++;
        if (mul_a !== '0)       $display("[TB] FAIL reset_mul_a: %0d required 0", mul_a);        else passed++;
        if (mul_b !== '0)       $display("[TB] FAIL reset_mul_b: %0d required 0", mul_b);        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int sp = start_pulses;
        int vp = valid_pulses;
        logic [ACC_W-1:0] got;
        out_ready = 1'b1;
        send_pair(3, 2, 0);
        send_pair(5, 5, 0);
        send_pair(4, 3, 0);
        send_pair(255, 255, 0);
        wait_results(1);
        got = results.pop_front();
        repeat (4) @(negedge clk);
        checks += 4;
        if (got !== 18'd65068)          $display("[TB] FAIL basic_dot: %0d required 65068", got);          else passed++;
        if (start_pulses - sp !== 4)    $display("[TB] FAIL basic_starts: %0d required 4", start_pulses - sp); else passed++;
        if (wide_starts !== 0)          $display("[TB] FAIL start_width: %0d wide pulses required 0", wide_starts); else passed++;
        if (valid_pulses - vp !== 1)    $display("[TB] FAIL basic_valid_pulses: %0d required 1", valid_pulses - vp); else passed++;
    endtask

    task automatic test_zero_and_max();
        logic [ACC_W-1:0] got;
        repeat (LEN) send_pair(255, 0, 0);
        wait_results(1);
        got = results.pop_front();
        checks++;
        if (got !== '0) $display("[TB] FAIL zero_dot: %0d required 0", got); else passed++;
        repeat (LEN) send_pair(255, 255, 0);
        wait_results(1);
        got = results.pop_front();
        checks++;
        if (got !== 18'd260100) $display("[TB] FAIL max_dot: %0d required 260100", got); else passed++;
    endtask

    task automatic test_backpressure();
        int va[$];
        int vb[$];
        int t = 0;
        int sp;
        logic [ACC_W-1:0] exp1;
        logic [ACC_W-1:0] got;
        out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            va.push_back(int'($urandom_range(0, 255)));
            vb.push_back(int'($urandom_range(0, 255)));
            send_pair(8'(va[i]), 8'(vb[i]), 0);
        end
        exp1 = ref_dot(va, vb);
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        in_a = 8'd7;
        in_b = 8'd9;
        sp = start_pulses;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: %b required 1", c, out_valid); else passed++;
            if (out_data !== exp1)  $display("[TB] FAIL hold_data[%0d]: %0d required %0d", c, out_data, exp1); else passed++;
            if (in_ready !== 1'b0)  $display("[TB] FAIL hold_in_ready[%0d]: %b required 0", c, in_ready); else passed++;
        end
        checks++;
        if (start_pulses !== sp) $display("[TB] FAIL hold_no_issue: %0d starts required %0d", start_pulses, sp); else passed++;
        out_ready = 1'b1;
        va.delete();
        vb.delete();
        va.push_back(7);
        vb.push_back(9);
        send_pair(7, 9, 0);
        for (int i = 1; i < LEN; i++) begin
            va.push_back(int'($urandom_range(0, 255)));
            vb.push_back(int'($urandom_range(0, 255)));
            send_pair(8'(va[i]), 8'(vb[i]), 0);
        end
        wait_results(2);
        got = results.pop_front();
        checks++;
        if (got !== exp1) $display("[TB] FAIL bp_first: %0d required %0d", got, exp1); else passed++;
        got = results.pop_front();
        checks++;
        if (got !== ref_dot(va, vb)) $display("[TB] FAIL bp_second: %0d required %0d", got, ref_dot(va, vb)); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] got;
        out_ready = 1'b1;
        repeat (LEN) send_pair(1, 1, 1);
        repeat (LEN) send_pair(2, 3, 1);
        in_valid = 1'b0;
        wait_results(2);
        got = results.pop_front();
        checks++;
        if (got !== 18'd4) $display("[TB] FAIL b2b_first: %0d required 4", got); else passed++;
        got = results.pop_front();
        checks++;
        if (got !== 18'd24) $display("[TB] FAIL b2b_second: %0d required 24", got); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [ACC_W-1:0] got;
        force_k = 6;
        send_pair(8'($urandom), 8'($urandom), 0);
        send_pair(8'($urandom), 8'($urandom), 0);
        send_pair(8'($urandom), 8'($urandom), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b1)  $display("[TB] FAIL mid_in_ready: %b required 1", in_ready);   else passed++;
        if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: %b required 0", out_valid); else passed++;
        if (out_data !== '0)    $display("[TB] FAIL mid_out_data: %0d required 0", out_data);  else passed++;
        if (mul_start !== 1'b0) $display("[TB] FAIL mid_mul_start: %b required 0", mul_start); else passed++;
        if (mul_a !== '0)       $display("[TB] FAIL mid_mul_a: %0d required 0", mul_a);        else passed++;
        if (mul_b !== '0)       $display("[TB] FAIL mid_mul_b: %0d required 0", mul_b);        else passed++;
        rst = 1'b0;
        force_k = 0;
        repeat (LEN) send_pair(1, 2, 0);
        wait_results(1);
        repeat (3) @(negedge clk);
        checks++;
        if (results.size() !== 1) $display("[TB] FAIL mid_result_count: %0d required 1", results.size()); else passed++;
        got = results.pop_front();
        checks++;
        if (got !== 18'd8) $display("[TB] FAIL mid_dot: %0d required 8", got); else passed++;
        results.delete();
    endtask

    task automatic test_random();
        int va[$];
        int vb[$];
        int t;
        logic [ACC_W-1:0] got;
        for (int v = 0; v < 8; v++) begin
            va.delete();
            vb.delete();
            out_ready = 1'b0;
            for (int i = 0; i < LEN; i++) begin
                va.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
                vb.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
                send_pair(8'(va[i]), 8'(vb[i]), 0);
            end
            t = 0;
            while (!out_valid && t < 300) begin
                @(negedge clk);
                t++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            wait_results(1);
            got = results.pop_front();
            checks++;
            if (got !== ref_dot(va, vb))
                $display("[TB] FAIL random_dot[%0d]: %0d required %0d", v, got, ref_dot(va, vb));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
